// File: rtl/lego_fpga_axis64_kvs.sv
// ---------------------------------------------------------------------------
// lego_fpga_axis64_kvs
//   Key-value store engine between the network RX and TX AXI-Stream paths.
//   It takes one GET/SET/DEL request packet at a time, looks the key up in a
//   direct-mapped on-chip table, and sends back one response packet.
//
//   Optional feature macro: KVS_DELETE_EN
//     defined   : opcode 0x03 deletes a matching entry.
//     undefined : opcode 0x03 is unknown and answers BAD_OP (0xFF).
//
// Ports
//   clk_390          in   1  network clock, all logic on the rising edge
//   clk_390_rst_n    in   1  synchronous active-low reset
//   mac_ready        in   1  MAC link up; a response is not started while low
//   from_net_tdata   in  64  request data (beat 0: key[63:32], opcode[7:0])
//   from_net_tkeep   in   8  ignored
//   from_net_tuser   in  64  ignored
//   from_net_tvalid  in   1  request beat valid
//   from_net_tlast   in   1  last request beat
//   from_net_tready  out  1  high in HDR, VAL and DRAIN only
//   to_net_tdata     out 64  response data
//   to_net_tkeep     out  8  constant 8'hFF
//   to_net_tuser     out 64  constant 0
//   to_net_tvalid    out  1  response beat valid
//   to_net_tlast     out  1  last response beat
//   to_net_tready    in   1  downstream accepts a beat
//
// States
//   state     | meaning
//   INIT      | clearing table valid bits, one entry per cycle
//   HDR       | waiting for request beat 0 (opcode/key)
//   VAL       | waiting for the SET value beat
//   DRAIN     | discarding surplus beats up to tlast (BAD_LEN)
//   LOOKUP    | table read issued
//   EXEC      | entry compared, status computed, table written
//   RESP_HDR  | sending the response header beat
//   RESP_VAL  | sending the GET value beat
// ---------------------------------------------------------------------------
module lego_fpga_axis64_kvs #(
    parameter int IDX_W = 10
) (
    input  logic        clk_390,
    input  logic        clk_390_rst_n,
    input  logic        mac_ready,
    input  logic [63:0] from_net_tdata,
    input  logic [7:0]  from_net_tkeep,
    input  logic [63:0] from_net_tuser,
    input  logic        from_net_tvalid,
    input  logic        from_net_tlast,
    output logic        from_net_tready,
    output logic [63:0] to_net_tdata,
    output logic [7:0]  to_net_tkeep,
    output logic [63:0] to_net_tuser,
    output logic        to_net_tvalid,
    output logic        to_net_tlast,
    input  logic        to_net_tready
);

    localparam int DEPTH = 1 << IDX_W;

    localparam logic [7:0] OP_GET = 8'h01;
    localparam logic [7:0] OP_SET = 8'h02;
    localparam logic [7:0] OP_DEL = 8'h03;

    localparam logic [7:0] ST_OK        = 8'h00;
    localparam logic [7:0] ST_MISS      = 8'h01;
    localparam logic [7:0] ST_COLLISION = 8'h02;
    localparam logic [7:0] ST_BAD_LEN   = 8'h03;
    localparam logic [7:0] ST_BAD_OP    = 8'hFF;

    typedef enum logic [2:0] {
        S_INIT,
        S_HDR,
        S_VAL,
        S_DRAIN,
        S_LOOKUP,
        S_EXEC,
        S_RESP_HDR,
        S_RESP_VAL
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IDX_W-1:0] r_init_cnt;
    logic [7:0]       r_op;
    logic [31:0]      r_key;
    logic [63:0]      r_val;
    logic             r_have_val;
    logic             r_bad_len;
    logic [7:0]       r_status;
    logic [63:0]      r_resp_val;

    // Table entry: {valid, key[31:0], value[63:0]}
    logic [96:0]      r_mem [DEPTH];
    logic [96:0]      r_rd;

    logic             r_tvalid;
    logic             r_tlast;
    logic [63:0]      r_tdata;

    logic             w_out_hs;
    logic [7:0]       w_beat_op;
    logic [IDX_W-1:0] w_idx;
    logic             w_rd_valid;
    logic [31:0]      w_rd_key;
    logic [63:0]      w_rd_val;
    logic             w_key_match;
    logic             w_hit;
    logic             w_op_known;
    logic             w_get_ok;
    logic [7:0]       w_status;
    logic             w_we;
    logic [96:0]      w_wdata;
    logic             w_unused;

    assign w_unused = ^{from_net_tkeep, from_net_tuser, from_net_tdata[31:8]};

    assign from_net_tready = (r_state == S_HDR) || (r_state == S_VAL) ||
                             (r_state == S_DRAIN);
    assign to_net_tdata    = r_tdata;
    assign to_net_tvalid   = r_tvalid;
    assign to_net_tlast    = r_tlast;
    assign to_net_tkeep    = 8'hFF;
    assign to_net_tuser    = '0;

    assign w_out_hs    = r_tvalid && to_net_tready;
    assign w_beat_op   = from_net_tdata[7:0];
    assign w_idx       = r_key[IDX_W-1:0];
    assign w_rd_valid  = r_rd[96];
    assign w_rd_key    = r_rd[95:64];
    assign w_rd_val    = r_rd[63:0];
    assign w_key_match = (w_rd_key == r_key);
    assign w_hit       = w_rd_valid && w_key_match;
    assign w_get_ok    = (r_op == OP_GET) && (r_status == ST_OK);

`ifdef KVS_DELETE_EN
    assign w_op_known = (r_op == OP_GET) || (r_op == OP_SET) || (r_op == OP_DEL);
`else
    assign w_op_known = (r_op == OP_GET) || (r_op == OP_SET);
`endif

    // Status and table write decision, evaluated against the entry read in LOOKUP
    always_comb begin
        w_status = ST_OK;
        w_we     = 1'b0;
        w_wdata  = {1'b1, r_key, r_val};
        if (!w_op_known) begin
            w_status = ST_BAD_OP;
        end else if (r_bad_len || ((r_op == OP_SET) && !r_have_val)) begin
            w_status = ST_BAD_LEN;
        end else begin
            case (r_op)
                OP_GET: begin
                    w_status = w_hit ? ST_OK : ST_MISS;
                end
                OP_SET: begin
                    if (!w_rd_valid || w_key_match) begin
                        w_we = 1'b1;
                    end else begin
                        w_status = ST_COLLISION;
                    end
                end
`ifdef KVS_DELETE_EN
                OP_DEL: begin
                    if (w_hit) begin
                        w_we    = 1'b1;
                        w_wdata = {1'b0, w_rd_key, w_rd_val};
                    end else begin
                        w_status = ST_MISS;
                    end
                end
`endif
                default: w_status = ST_BAD_OP;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:     if (r_init_cnt == '0) w_next = S_HDR;
            S_HDR: begin
                if (from_net_tvalid) begin
                    if (from_net_tlast)          w_next = S_LOOKUP;
                    else if (w_beat_op == OP_SET) w_next = S_VAL;
                    else                          w_next = S_DRAIN;
                end
            end
            S_VAL: begin
                if (from_net_tvalid) w_next = from_net_tlast ? S_LOOKUP : S_DRAIN;
            end
            S_DRAIN:    if (from_net_tvalid && from_net_tlast) w_next = S_LOOKUP;
            S_LOOKUP:   w_next = S_EXEC;
            S_EXEC:     w_next = S_RESP_HDR;
            S_RESP_HDR: if (w_out_hs) w_next = w_get_ok ? S_RESP_VAL : S_HDR;
            S_RESP_VAL: if (w_out_hs) w_next = S_HDR;
            default:    w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk_390) begin
        if (!clk_390_rst_n) r_state <= S_INIT;
        else                r_state <= w_next;
    end

    // Table RAM: INIT sweep clears entries, EXEC performs the single write,
    // LOOKUP registers the read so EXEC sees it a cycle later.
    always_ff @(posedge clk_390) begin
        if (r_state == S_INIT) begin
            r_mem[r_init_cnt] <= '0;
        end else if ((r_state == S_EXEC) && w_we) begin
            r_mem[w_idx] <= w_wdata;
        end
        if (r_state == S_LOOKUP) begin
            r_rd <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk_390) begin
        if (!clk_390_rst_n) begin
            r_init_cnt <= '1;
            r_op       <= '0;
            r_key      <= '0;
            r_val      <= '0;
            r_have_val <= 1'b0;
            r_bad_len  <= 1'b0;
            r_status   <= '0;
            r_resp_val <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tdata    <= '0;
        end else begin
            if (r_state == S_INIT) begin
                r_init_cnt <= r_init_cnt - 1'b1;
            end
            case (r_state)
                S_HDR: begin
                    if (from_net_tvalid) begin
                        r_op       <= w_beat_op;
                        r_key      <= from_net_tdata[63:32];
                        r_have_val <= 1'b0;
                        r_bad_len  <= !from_net_tlast && (w_beat_op != OP_SET);
                    end
                end
                S_VAL: begin
                    if (from_net_tvalid) begin
                        r_val      <= from_net_tdata;
                        r_have_val <= 1'b1;
                        if (!from_net_tlast) r_bad_len <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_status   <= w_status;
                    r_resp_val <= w_rd_val;
                end
                S_RESP_HDR: begin
                    // mac_ready only gates raising tvalid; once up it holds
                    if (!r_tvalid) begin
                        if (mac_ready) begin
                            r_tvalid <= 1'b1;
                            r_tdata  <= {r_key, 16'h0000, r_status, r_op};
                            r_tlast  <= !w_get_ok;
                        end
                    end else if (to_net_tready) begin
                        if (w_get_ok) begin
                            r_tdata <= r_resp_val;
                            r_tlast <= 1'b1;
                        end else begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_tdata  <= '0;
                        end
                    end
                end
                S_RESP_VAL: begin
                    if (to_net_tready) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_tdata  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lego_fpga_axis64_kvs.sv
module tb_lego_fpga_axis64_kvs;

    logic        clk_390 = 1'b0;
    logic        clk_390_rst_n;
    logic        mac_ready;
    logic [63:0] from_net_tdata;
    logic [7:0]  from_net_tkeep;
    logic [63:0] from_net_tuser;
    logic        from_net_tvalid;
    logic        from_net_tlast;
    logic        from_net_tready;
    logic [63:0] to_net_tdata;
    logic [7:0]  to_net_tkeep;
    logic [63:0] to_net_tuser;
    logic        to_net_tvalid;
    logic        to_net_tlast;
    logic        to_net_tready;

    always #5 clk_390 = ~clk_390;

    lego_fpga_axis64_kvs #(.IDX_W(10)) dut (
        .clk_390         (clk_390),
        .clk_390_rst_n   (clk_390_rst_n),
        .mac_ready       (mac_ready),
        .from_net_tdata  (from_net_tdata),
        .from_net_tkeep  (from_net_tkeep),
        .from_net_tuser  (from_net_tuser),
        .from_net_tvalid (from_net_tvalid),
        .from_net_tlast  (from_net_tlast),
        .from_net_tready (from_net_tready),
        .to_net_tdata    (to_net_tdata),
        .to_net_tkeep    (to_net_tkeep),
        .to_net_tuser    (to_net_tuser),
        .to_net_tvalid   (to_net_tvalid),
        .to_net_tlast    (to_net_tlast),
        .to_net_tready   (to_net_tready)
    );

`ifdef KVS_DELETE_EN
    localparam bit DEL_EN = 1'b1;
`else
    localparam bit DEL_EN = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    // Reference table: what a direct-mapped store of 1024 slots holds
    bit          m_valid [1024];
    logic [31:0] m_key   [1024];
    logic [63:0] m_val   [1024];

    // Expectation for the request in flight
    logic [63:0] e_hdr;
    logic [63:0] e_val;
    int          e_nb;

    // Observed response
    logic [63:0] r_d0;
    logic [63:0] r_d1;
    int          r_nb;
    int          r_lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    endtask

    // Computes the response the request should get and applies its effect.
    task automatic model_exec(input logic [7:0] op, input logic [31:0] key,
                              input logic [63:0] val, input int nb);
        int         idx;
        logic [7:0] st;
        bit         known;
        bit         hit;
        int         want_nb;
        idx     = int'(key[9:0]);
        known   = (op == 8'h01) || (op == 8'h02) || ((op == 8'h03) && DEL_EN);
        hit     = m_valid[idx] && (m_key[idx] == key);
        want_nb = (op == 8'h02) ? 2 : 1;
        e_val   = m_val[idx];
        if (!known)              st = 8'hFF;
        else if (nb != want_nb)  st = 8'h03;
        else if (op == 8'h01)    st = hit ? 8'h00 : 8'h01;
        else if (op == 8'h02) begin
            if (!m_valid[idx] || m_key[idx] == key) begin
                st = 8'h00;
                m_valid[idx] = 1'b1;
                m_key[idx]   = key;
                m_val[idx]   = val;
            end else begin
                st = 8'h02;
            end
        end else begin
            if (hit) begin
                st = 8'h00;
                m_valid[idx] = 1'b0;
            end else begin
                st = 8'h01;
            end
        end
        e_hdr = {key, 16'h0000, st, op};
        e_nb  = (op == 8'h01 && st == 8'h00) ? 2 : 1;
    endtask

    task automatic send_req(input logic [7:0] op, input logic [31:0] key,
                            input logic [63:0] val, input int nb);
        int w;
        for (int b = 0; b < nb; b++) begin
            if (b == 0)      from_net_tdata = {key, 24'($urandom), op};
            else if (b == 1) from_net_tdata = val;
            else             from_net_tdata = {$urandom, $urandom};
            from_net_tkeep  = 8'($urandom);
            from_net_tuser  = {$urandom, $urandom};
            from_net_tlast  = (b == nb - 1);
            from_net_tvalid = 1'b1;
            w = 0;
            while (!from_net_tready && w < 4000) begin
                @(posedge clk_390); #1;
                w++;
            end
            if (!from_net_tready) begin
                check("req_accept", from_net_tready, 1);
                from_net_tvalid = 1'b0;
                from_net_tlast  = 1'b0;
                return;
            end
            @(posedge clk_390); #1;
        end
        from_net_tvalid = 1'b0;
        from_net_tlast  = 1'b0;
    endtask

    task automatic recv(input bit rand_stall);
        logic [63:0] cur;
        logic        lst;
        bit          hs;
        int          w;
        r_nb  = 0;
        r_lat = 0;
        r_d0  = '0;
        r_d1  = '0;
        while (!to_net_tvalid && r_lat < 3000) begin
            @(posedge clk_390); #1;
            r_lat++;
        end
        if (!to_net_tvalid) begin
            check("resp_timeout", to_net_tvalid, 1);
            return;
        end
        for (int b = 0; b < 2; b++) begin
            cur = to_net_tdata;
            lst = to_net_tlast;
            if (b == 0) r_d0 = cur;
            else        r_d1 = cur;
            r_nb++;
            check("resp_tkeep", to_net_tkeep, 64'hFF);
            check("resp_tuser", to_net_tuser, 64'h0);
            hs = 1'b0;
            w  = 0;
            while (!hs) begin
                to_net_tready = (rand_stall && w < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
                hs = to_net_tready;
                @(posedge clk_390); #1;
                w++;
                if (!hs) begin
                    check("stall_valid", to_net_tvalid, 1);
                    check("stall_data", to_net_tdata, cur);
                    check("stall_last", to_net_tlast, lst);
                end
            end
            if (lst) break;
            check("beat2_valid", to_net_tvalid, 1);
        end
        to_net_tready = 1'b1;
        check("resp_done_valid", to_net_tvalid, 0);
    endtask

    task automatic run_req(input logic [7:0] op, input logic [31:0] key,
                           input logic [63:0] val, input int nb, input bit stall);
        model_exec(op, key, val, nb);
        send_req(op, key, val, nb);
        recv(stall);
        check("hdr", r_d0, e_hdr);
        check("nbeats", r_nb, e_nb);
        check("latency", r_lat, 3);
        if (e_nb == 2) check("value", r_d1, e_val);
    endtask

    task automatic wait_tvalid();
        int w;
        w = 0;
        while (!to_net_tvalid && w < 100) begin
            @(posedge clk_390); #1;
            w++;
        end
        check("wait_tvalid", to_net_tvalid, 1);
    endtask

    logic [63:0] hold_d;
    logic        hold_l;
    logic [7:0]  rop;
    logic [31:0] rkey;
    int          rnb;
    int          sel;

    initial begin
        clk_390_rst_n   = 1'b0;
        mac_ready       = 1'b1;
        to_net_tready   = 1'b1;
        from_net_tvalid = 1'b0;
        from_net_tlast  = 1'b0;
        from_net_tdata  = '0;
        from_net_tkeep  = '0;
        from_net_tuser  = '0;
        model_clear();

        // Reset values
        repeat (3) @(posedge clk_390);
        #1;
        check("rst_from_tready", from_net_tready, 0);
        check("rst_tvalid", to_net_tvalid, 0);
        check("rst_tlast", to_net_tlast, 0);
        check("rst_tdata", to_net_tdata, 0);
        check("rst_tkeep", to_net_tkeep, 64'hFF);
        check("rst_tuser", to_net_tuser, 0);

        // INIT lasts exactly 1024 cycles
        clk_390_rst_n = 1'b1;
        for (int k = 1; k <= 1024; k++) begin
            @(posedge clk_390); #1;
            if (k == 1 || k == 1023) check("init_tready_low", from_net_tready, 0);
        end
        check("init_done_tready", from_net_tready, 1);

        // GET on empty table
        run_req(8'h01, 32'h5, 64'h0, 1, 1'b0);
        check("get_miss_const", r_d0, 64'h00000005_0000_0101);

        // SET then GET hit
        run_req(8'h02, 32'h5, 64'hDEADBEEF_CAFEF00D, 2, 1'b0);
        check("set_ok_const", r_d0, 64'h00000005_0000_0002);
        run_req(8'h01, 32'h5, 64'h0, 1, 1'b0);
        check("get_hit_hdr_const", r_d0, 64'h00000005_0000_0001);
        check("get_hit_val_const", r_d1, 64'hDEADBEEF_CAFEF00D);

        // Same index, different key
        run_req(8'h02, 32'h405, 64'h1111_2222_3333_4444, 2, 1'b0);
        check("collision_const", r_d0, 64'h00000405_0000_0202);
        run_req(8'h01, 32'h5, 64'h0, 1, 1'b0);
        check("old_val_const", r_d1, 64'hDEADBEEF_CAFEF00D);

        // Opcode 0x03
        run_req(8'h03, 32'h5, 64'h0, 1, 1'b0);
        check("del_const", r_d0, DEL_EN ? 64'h00000005_0000_0003 : 64'h00000005_0000_FF03);
        run_req(8'h01, 32'h5, 64'h0, 1, 1'b0);
        check("get_after_del_const", r_d0, DEL_EN ? 64'h00000005_0000_0101 : 64'h00000005_0000_0001);
        run_req(8'h02, 32'h5, 64'hDEADBEEF_CAFEF00D, 2, 1'b0);

        // Length errors
        run_req(8'h02, 32'h7, 64'h0, 1, 1'b0);
        check("set_short_const", r_d0, 64'h00000007_0000_0302);
        run_req(8'h01, 32'h7, 64'h0, 3, 1'b0);
        check("get_long_const", r_d0, 64'h00000007_0000_0301);
        run_req(8'h01, 32'h5, 64'h0, 1, 1'b0);
        check("get_after_drain_const", r_d1, 64'hDEADBEEF_CAFEF00D);

        // Downstream stall of 10 cycles on a GET hit
        model_exec(8'h01, 32'h5, 64'h0, 1);
        to_net_tready = 1'b0;
        send_req(8'h01, 32'h5, 64'h0, 1);
        wait_tvalid();
        hold_d = to_net_tdata;
        hold_l = to_net_tlast;
        check("stall_hdr_start", hold_d, e_hdr);
        repeat (10) begin
            @(posedge clk_390); #1;
            check("hold_valid", to_net_tvalid, 1);
            check("hold_data", to_net_tdata, hold_d);
            check("hold_last", to_net_tlast, hold_l);
        end
        recv(1'b0);
        check("stall_hdr", r_d0, e_hdr);
        check("stall_val", r_d1, e_val);
        check("stall_nb", r_nb, 2);

        // mac_ready low withholds the response
        mac_ready = 1'b0;
        model_exec(8'h01, 32'h5, 64'h0, 1);
        send_req(8'h01, 32'h5, 64'h0, 1);
        repeat (10) begin
            @(posedge clk_390); #1;
            check("withheld", to_net_tvalid, 0);
        end
        mac_ready = 1'b1;
        recv(1'b0);
        check("mac_lat", r_lat, 1);
        check("mac_hdr", r_d0, e_hdr);
        check("mac_val", r_d1, e_val);

        // Reset in the middle of a response
        to_net_tready = 1'b0;
        send_req(8'h01, 32'h5, 64'h0, 1);
        wait_tvalid();
        clk_390_rst_n = 1'b0;
        @(posedge clk_390); #1;
        check("midrst_tvalid", to_net_tvalid, 0);
        check("midrst_tlast", to_net_tlast, 0);
        check("midrst_tdata", to_net_tdata, 0);
        check("midrst_from_tready", from_net_tready, 0);
        clk_390_rst_n = 1'b1;
        to_net_tready = 1'b1;
        model_clear();
        run_req(8'h01, 32'h5, 64'h0, 1, 1'b0);
        check("cleared_after_rst", r_d0, 64'h00000005_0000_0101);

        // Randomized traffic against the reference table
        for (int n = 0; n < 80; n++) begin
            rkey = (32'($urandom_range(0, 2)) << 10) | 32'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) rkey = rkey | 32'h8000_0000;
            sel = int'($urandom_range(0, 9));
            if (sel <= 3)      rop = 8'h01;
            else if (sel <= 6) rop = 8'h02;
            else if (sel <= 8) rop = 8'h03;
            else               rop = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hA5;
            rnb = (rop == 8'h02) ? 2 : 1;
            if ($urandom_range(0, 5) == 0) rnb = int'($urandom_range(1, 3));
            run_req(rop, rkey, {$urandom, $urandom}, rnb, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
